// File: rtl/reg_exec_unit.sv
// ============================================================================
// Module   : reg_exec_unit
// Purpose  : Four-cycle execute/write-back sequencer for an 8x8 register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_exec_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [15:0] inst,
  output logic [2:0]  RX,
  output logic [2:0]  RY,
  input  logic [7:0]  busX,
  input  logic [7:0]  busY,
  output logic [2:0]  RW,
  output logic [7:0]  busW,
  output logic        WEN,
  output logic        done,
  output logic        illegal,
  output logic        carry
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0] r_state;
  logic [3:0] r_op;
  logic [2:0] r_rd;
  logic [5:0] r_imm;
  logic [7:0] r_a;
  logic [7:0] r_b;

  logic       w_legal;
  logic [7:0] w_result;
  logic       w_carry;
  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic [8:0] w_sumi;

  assign w_legal    = (r_op < 4'd10);
  assign inst_ready = (r_state == S_IDLE);
  assign done       = (r_state == S_WB);
  assign illegal    = done && !w_legal;

  // Ninth bit of each 9-bit sum/difference is the carry or borrow out.
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};
  assign w_sumi = {1'b0, r_a} + {1'b0, {{2{r_imm[5]}}, r_imm}};

  always_comb begin
    w_result = 8'h00;
    w_carry  = carry;
    case (r_op)
      4'd0: begin w_result = w_sum[7:0];  w_carry = w_sum[8];  end
      4'd1: begin w_result = w_diff[7:0]; w_carry = w_diff[8]; end
      4'd2: w_result = r_a & r_b;
      4'd3: w_result = r_a | r_b;
      4'd4: w_result = r_a ^ r_b;
      4'd5: w_result = {7'b0, ($signed(r_a) < $signed(r_b))};
      4'd6: w_result = r_a << r_b[2:0];
      4'd7: w_result = r_a >> r_b[2:0];
      4'd8: begin w_result = w_sumi[7:0]; w_carry = w_sumi[8]; end
      4'd9: w_result = {2'b00, r_imm};
      default: w_result = 8'h00;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_op    <= 4'd0;
      r_rd    <= 3'd0;
      r_imm   <= 6'd0;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      RX      <= 3'd0;
      RY      <= 3'd0;
      RW      <= 3'd0;
      busW    <= 8'h00;
      WEN     <= 1'b0;
      carry   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (inst_valid) begin
            r_op    <= inst[15:12];
            r_rd    <= inst[11:9];
            r_imm   <= inst[5:0];
            RX      <= inst[8:6];
            RY      <= inst[5:3];
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_a     <= busX;
          r_b     <= busY;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          RW      <= r_rd;
          busW    <= w_result;
          WEN     <= w_legal && (r_rd != 3'd0);
          carry   <= w_carry;
          r_state <= S_WB;
        end
        S_WB: begin
          WEN     <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
